// File: rtl/combat_referee.sv
// Frame-synchronous duel referee: room exits, sword clashes and sword-to-body hits,
// with kill/clash/respawn timing, signed room index and match winner.
module combat_referee #(
    parameter int W            = 12,
    parameter int SCREEN_W     = 1024,
    parameter int EDGE         = 40,
    parameter int PLAYER_W     = 64,
    parameter int PLAYER_H     = 128,
    parameter int SWORD_LEN    = 32,
    parameter int HIT_OFS      = 24,
    parameter int HIT_DEPTH    = 40,
    parameter int CLASH_TOL    = 0,
    parameter int DEAD_FRAMES  = 60,
    parameter int CLASH_FRAMES = 8,
    parameter int ROOMS        = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         frame_tick,
    input  logic [W-1:0] xpos_playerL,
    input  logic [W-1:0] ypos_playerL,
    input  logic [W-1:0] xpos_playerR,
    input  logic [W-1:0] ypos_playerR,
    input  logic [W-1:0] xpos_sword_L,
    input  logic [W-1:0] ypos_sword_L,
    input  logic [W-1:0] xpos_sword_R,
    input  logic [W-1:0] ypos_sword_R,
    output logic         dead_L,
    output logic         dead_R,
    output logic         collision,
    output logic         pos_reset,
    output logic [3:0]   room,
    output logic [1:0]   winner,
    output logic         busy
);

    localparam logic [2:0] S_PLAY  = 3'd0;
    localparam logic [2:0] S_CLASH = 3'd1;
    localparam logic [2:0] S_KILL  = 3'd2;
    localparam logic [2:0] S_ROOM  = 3'd3;
    localparam logic [2:0] S_WIN   = 3'd4;

    localparam int GW = W + 2;
    localparam logic signed [GW-1:0] C_SW   = GW'(SCREEN_W);
    localparam logic signed [GW-1:0] C_EDGE = GW'(EDGE);
    localparam logic signed [GW-1:0] C_PW   = GW'(PLAYER_W);
    localparam logic signed [GW-1:0] C_PH   = GW'(PLAYER_H);
    localparam logic signed [GW-1:0] C_SL   = GW'(SWORD_LEN);
    localparam logic signed [GW-1:0] C_HO   = GW'(HIT_OFS);
    localparam logic signed [GW-1:0] C_HD   = GW'(HIT_DEPTH);
    localparam logic signed [GW-1:0] C_TOL  = GW'(CLASH_TOL);

    localparam int MAXF = (DEAD_FRAMES > CLASH_FRAMES) ? DEAD_FRAMES : CLASH_FRAMES;
    localparam int CW   = $clog2(MAXF + 2);

    localparam logic signed [3:0] RMAX = 4'(ROOMS);
    localparam logic signed [3:0] RMIN = -RMAX;

    logic [2:0]          state;
    logic [CW-1:0]       cnt;
    logic signed [3:0]   room_q;
    logic signed [3:0]   room_nx;

    logic signed [GW-1:0] xl, yl, xr, yr, xsl, ysl, xsr, ysr;
    logic signed [GW-1:0] clash_d;
    logic                 hit_l, hit_r, clash, exit_l, exit_r, exit_any;

    // Two guard bits keep inset/offset arithmetic from wrapping near x = 0.
    assign xl  = $signed({2'b00, xpos_playerL});
    assign yl  = $signed({2'b00, ypos_playerL});
    assign xr  = $signed({2'b00, xpos_playerR});
    assign yr  = $signed({2'b00, ypos_playerR});
    assign xsl = $signed({2'b00, xpos_sword_L});
    assign ysl = $signed({2'b00, ypos_sword_L});
    assign xsr = $signed({2'b00, xpos_sword_R});
    assign ysr = $signed({2'b00, ypos_sword_R});

    assign hit_l = (xsr > xl + C_PW - C_HO - C_HD) && (xsr <= xl + C_PW - C_HO) &&
                   (ysr > yl) && (ysr < yl + C_PH);
    assign hit_r = (xsl >= xr - C_HO) && (xsl < xr - C_HO + C_HD) &&
                   (ysl > yr) && (ysl < yr + C_PH);

    assign clash_d = xsr - (xsl + C_SL);
    assign clash   = (ysl == ysr) && (clash_d <= C_TOL) && (clash_d >= -C_TOL);

    assign exit_r   = (xr <= C_EDGE);
    assign exit_l   = (xl >= C_SW - C_EDGE - C_PW);
    assign exit_any = exit_r || exit_l;

    // Right-player exit takes priority; index saturates at the match-ending rooms.
    always_comb begin
        room_nx = room_q;
        if (exit_r) begin
            if (room_q != RMIN) room_nx = room_q - 4'sd1;
        end else if (exit_l) begin
            if (room_q != RMAX) room_nx = room_q + 4'sd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_PLAY;
            cnt       <= '0;
            room_q    <= '0;
            winner    <= '0;
            dead_L    <= 1'b0;
            dead_R    <= 1'b0;
            collision <= 1'b0;
            pos_reset <= 1'b0;
        end else begin
            collision <= 1'b0;
            pos_reset <= 1'b0;
            case (state)
                S_PLAY: begin
                    if (frame_tick) begin
                        if (exit_any) begin
                            room_q    <= room_nx;
                            pos_reset <= 1'b1;
                            cnt       <= '0;
                            state     <= S_ROOM;
                        end else if (clash) begin
                            collision <= 1'b1;
                            cnt       <= CW'(CLASH_FRAMES);
                            state     <= S_CLASH;
                        end else if (hit_l || hit_r) begin
                            dead_L <= hit_l;
                            dead_R <= hit_r;
                            cnt    <= CW'(DEAD_FRAMES);
                            state  <= S_KILL;
                        end
                    end
                end
                S_CLASH: begin
                    if (frame_tick) begin
                        if (exit_any) begin
                            room_q    <= room_nx;
                            pos_reset <= 1'b1;
                            cnt       <= '0;
                            state     <= S_ROOM;
                        end else if (cnt <= CW'(1)) begin
                            cnt   <= '0;
                            state <= S_PLAY;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                end
                S_KILL: begin
                    if (frame_tick) begin
                        if (cnt <= CW'(1)) begin
                            cnt       <= '0;
                            dead_L    <= 1'b0;
                            dead_R    <= 1'b0;
                            pos_reset <= 1'b1;
                            state     <= S_PLAY;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                end
                S_ROOM: begin
                    if (room_q == RMIN) begin
                        winner <= 2'b10;
                        state  <= S_WIN;
                    end else if (room_q == RMAX) begin
                        winner <= 2'b01;
                        state  <= S_WIN;
                    end else begin
                        state <= S_PLAY;
                    end
                end
                S_WIN: begin
                    dead_L <= 1'b0;
                    dead_R <= 1'b0;
                end
                default: state <= S_PLAY;
            endcase
        end
    end

    assign room = room_q;
    assign busy = (state != S_PLAY);

endmodule

// File: tb/tb_combat_referee.sv
// Scoreboard bench for combat_referee: each driven cycle queues the expected outputs
// for the following edge; a negedge monitor pops and compares them.
module tb_combat_referee;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         reset;
    logic         frame_tick;
    logic [W-1:0] xl, yl, xr, yr, xsl, ysl, xsr, ysr;
    logic         dead_L, dead_R, collision, pos_reset, busy;
    logic [3:0]   room;
    logic [1:0]   winner;

    always #5 clk = ~clk;

    combat_referee dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .xpos_playerL(xl), .ypos_playerL(yl),
        .xpos_playerR(xr), .ypos_playerR(yr),
        .xpos_sword_L(xsl), .ypos_sword_L(ysl),
        .xpos_sword_R(xsr), .ypos_sword_R(ysr),
        .dead_L(dead_L), .dead_R(dead_R), .collision(collision),
        .pos_reset(pos_reset), .room(room), .winner(winner), .busy(busy)
    );

    typedef struct {
        int          due;
        string       tag;
        logic [10:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic       e_dl, e_dr, e_busy;
    logic [3:0] e_room;
    logic [1:0] e_win;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (dl,dr,col,pr,room,win,busy)", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check(e.tag, {21'd0, dead_L, dead_R, collision, pos_reset, room, winner, busy},
                  {21'd0, e.val});
        end
    end

    task automatic step(input logic tick, input string tag,
                        input logic col = 1'b0, input logic pr = 1'b0);
        exp_t e;
        frame_tick = tick;
        e.due = cyc + 1;
        e.tag = tag;
        e.val = {e_dl, e_dr, col, pr, e_room, e_win, e_busy};
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Positions that trigger no exit, hit or clash.
    task automatic neutral();
        xl = 300; yl = 200; xr = 600; yr = 200;
        xsl = 100; ysl = 100; xsr = 800; ysr = 50;
    endtask

    task automatic kill_tail(input string tag);
        for (int i = 0; i < 59; i++) step(1'b1, tag);
        e_dl = 1'b0; e_dr = 1'b0; e_busy = 1'b0;
        step(1'b1, {tag, "_end"}, 1'b0, 1'b1);
        step(1'b0, {tag, "_post"});
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; neutral();
        e_dl = 0; e_dr = 0; e_busy = 0; e_room = 4'h0; e_win = 2'b00;
        @(posedge clk); #1;

        step(1'b0, "reset");
        xsr = 320; ysr = 250;
        step(1'b1, "reset_with_hit");
        neutral();
        reset = 1'b0;
        step(1'b1, "idle_tick");

        // Single kill, ticks every other cycle, exit geometry ignored mid-kill
        xsr = 320; ysr = 250;
        e_dl = 1; e_busy = 1;
        step(1'b1, "hit_L");
        for (int i = 1; i <= 59; i++) begin
            step(1'b0, "kill_gap");
            if (i == 10) xr = 40;
            if (i == 20) xr = 600;
            step(1'b1, "kill_tick");
        end
        e_dl = 0; e_busy = 0;
        step(1'b1, "kill_end", 1'b0, 1'b1);
        neutral();
        step(1'b0, "kill_post");

        // Double kill
        xsr = 320; ysr = 250; xsl = 590; ysl = 260;
        e_dl = 1; e_dr = 1; e_busy = 1;
        step(1'b1, "double_kill");
        neutral();
        kill_tail("dk");

        // Clash tolerance edge, then exact clash and cooldown
        ysl = 250; ysr = 250; xsl = 400; xsr = 433;
        step(1'b1, "clash_tol_miss");
        xsr = 432; e_busy = 1;
        step(1'b1, "clash", 1'b1, 1'b0);
        step(1'b0, "clash_post");
        ysl = 100; xsr = 320; ysr = 250;
        for (int i = 0; i < 7; i++) step(1'b1, "clash_cool");
        e_busy = 0;
        step(1'b1, "clash_done");
        e_dl = 1; e_busy = 1;
        step(1'b1, "hit_after_clash");
        neutral();
        kill_tail("hac");

        // Exit boundaries
        xr = 41;
        step(1'b1, "xr41_no_exit");
        xr = 600; xl = 919;
        step(1'b1, "xl919_no_exit");
        neutral();

        // Exit during clash cooldown cancels it
        ysl = 250; ysr = 250; xsl = 400; xsr = 432; e_busy = 1;
        step(1'b1, "clash2", 1'b1, 1'b0);
        neutral(); xl = 920; e_room = 4'h1;
        step(1'b1, "exit_L_in_clash", 1'b0, 1'b1);
        neutral(); e_busy = 0;
        step(1'b0, "room_p1");
        xsr = 320; ysr = 250; e_dl = 1; e_busy = 1;
        step(1'b1, "hit_after_exit");
        neutral();
        kill_tail("hae");

        // Room walk to the right player's win
        xr = 40; e_room = 4'h0; e_busy = 1;
        step(1'b1, "exit_R_1", 1'b0, 1'b1);
        neutral(); e_busy = 0;
        step(1'b0, "room_0");
        xr = 40; xl = 920; e_room = 4'hF; e_busy = 1;
        step(1'b1, "exit_both", 1'b0, 1'b1);
        neutral(); e_busy = 0;
        step(1'b0, "room_m1");
        xr = 0; xsl = 4090; ysl = 260; e_room = 4'hE; e_busy = 1;
        step(1'b1, "exit_R_x0", 1'b0, 1'b1);
        neutral(); e_busy = 0;
        step(1'b0, "room_m2");
        xr = 40; e_room = 4'hD; e_busy = 1;
        step(1'b1, "exit_R_3", 1'b0, 1'b1);
        neutral(); e_win = 2'b10;
        step(1'b0, "win");
        xsr = 320; ysr = 250;
        step(1'b1, "win_hit");
        neutral(); xl = 920;
        step(1'b1, "win_exit");
        ysl = 250; ysr = 250; xsl = 400; xsr = 432; xl = 300;
        step(1'b1, "win_clash");
        neutral();

        reset = 1'b1;
        e_dl = 0; e_dr = 0; e_busy = 0; e_room = 4'h0; e_win = 2'b00;
        step(1'b0, "reset_from_win");
        reset = 1'b0;
        step(1'b1, "post_reset_idle");

        // Reset during a kill aborts without a respawn pulse
        xsr = 320; ysr = 250; e_dl = 1; e_busy = 1;
        step(1'b1, "hit_before_reset");
        neutral();
        step(1'b1, "kill_before_reset");
        reset = 1'b1; e_dl = 0; e_busy = 0;
        step(1'b1, "reset_mid_kill");
        reset = 1'b0;
        step(1'b0, "after_reset_kill");
        step(1'b1, "after_reset_tick");

        @(negedge clk);
        @(negedge clk);
        check("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
